fu_jump_pipe: RTL and testbench
===============================

Name: fu_jump_pipe

Overview:
- Parametrised branch/jump functional unit for the out-of-order core. Successor to the fixed 32-bit, fixed one-cycle-delay jump unit.
- Computes branch condition, jump target and link value (PC+4) over a configurable-depth pipeline.
- Carries a reservation tag; has valid/ready handshakes on issue and writeback, plus flush.
- Sits between the issue/reservation stage and the common data bus / PC redirect logic.

Parameters:
- XLEN, 32: data and PC width.
- LATENCY, 2: cycles from accepted issue to result valid; legal range 1..4.
- TAG_W, 4: reservation-station tag width.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous active-high reset.
- flush  in  1: kill all in-flight ops (mispredict/exception).
- in_valid  in  1: issue request.
- in_ready  out  1: unit can accept this cycle.
- JALR  in  1: target base is rs1 (else PC).
- cmp_ctrl  in  3: compare op.
- rs1_data, rs2_data, imm, PC  in  XLEN each: operands.
- tag_in  in  TAG_W: issuing RS tag.
- out_valid  out  1: result valid.
- out_ready  in  1: writeback/CDB accepts result.
- PC_jump  out  XLEN: target address.
- PC_wb  out  XLEN: PC+4 link value.
- cmp_res  out  1: branch condition result.
- tag_out  out  TAG_W: tag of the result op.

Behaviour:
- Pipeline has LATENCY register stages. Each stage holds a valid bit plus JALR, cmp_ctrl, rs1, rs2, imm, PC and tag.
- Stage 0 loads on the issue handshake (in_valid & in_ready). Stages advance one per cycle.
- Outputs are computed combinationally from the last stage only.
- Stall: stall = out_valid & ~out_ready. While stall is high:
  - every stage holds its contents;
  - in_ready = 0.
- in_ready = ~stall & ~flush.
- Bubbles do not collapse. The pipe advances as a whole or holds as a whole.
- Latency: an op accepted at edge k with no stall gives out_valid = 1 in the cycle after edge k+LATENCY-1. For LATENCY=1, out_valid is high the cycle after issue.
- Throughput: one op per cycle when out_ready stays high.
- Outputs are held stable while out_valid & ~out_ready.
- Operation completes on out_valid & out_ready.
- cmp_ctrl encoding (signed compares are two's complement; LTU/GEU are unsigned):
  - 000: none, cmp_res = 0
  - 001: EQ
  - 010: NE
  - 011: LT signed
  - 100: GE signed
  - 101: LTU
  - 110: GEU
  - 111: reserved, cmp_res = 0
- PC_jump = (JALR ? rs1 : PC) + imm, modulo 2^XLEN; carry discarded.
- PC_wb = PC + 4, modulo 2^XLEN. Wrap-around is required: PC = all-ones minus 3 gives PC_wb = 0.
- flush:
  - synchronous; clears all stage valid bits at the next edge;
  - takes priority over issue and over stall; an issue in the flush cycle is refused (in_ready = 0);
  - out_valid is 0 the cycle after flush.
- Reset (async, immediate):
  - all valid bits 0; datapath registers 0;
  - out_valid = 0, in_ready = 1 (after reset deasserts), tag_out = 0, PC_jump = 0, PC_wb = 4, cmp_res = 0.
  - Reset mid-operation discards all in-flight ops with no output.
- When out_valid = 0, data outputs reflect the last stage registers but are don't-care for consumers.

Optional Feature:
- Macro FU_JUMP_JALR_ALIGN_EN.
- Defined: when JALR = 1, PC_jump bit 0 is forced to 0 (RISC-V JALR semantics).
- Undefined: PC_jump is the raw sum.
- Branches and JAL are unaffected in both cases.

Test Plan:
- Basic latency (LATENCY=2):
  - Stimulus: issue PC=0x100, imm=0x20, JALR=0, cmp_ctrl=001, rs1=rs2=5, tag=3; out_ready=1.
  - Response: out_valid exactly 2 cycles later with PC_jump=0x120, PC_wb=0x104, cmp_res=1, tag_out=3.
- Signed vs unsigned compare:
  - Stimulus: rs1=0xFFFFFFFF, rs2=1 with cmp_ctrl=011, then back-to-back with cmp_ctrl=101.
  - Response: cmp_res=1 then 0, on consecutive cycles.
- JALR with odd target:
  - Stimulus: JALR=1, rs1=0x2001, imm=0x4.
  - Response: PC_jump=0x2005 without the macro; 0x2004 with FU_JUMP_JALR_ALIGN_EN.
- Backpressure:
  - Stimulus: 3 back-to-back issues (tags 1,2,3); out_ready=0 for 4 cycles once tag 1 reaches the output.
  - Response: in_ready=0 and outputs hold tag 1 throughout the stall; then tags 1,2,3 emerge in order on consecutive cycles.
- Flush:
  - Stimulus: issue tags 4,5; assert flush one cycle later, with a simultaneous issue of tag 6.
  - Response: in_ready=0 in the flush cycle; no out_valid for tags 4, 5 or 6.
- Async reset and wrap:
  - Stimulus: assert rst mid-pipe.
  - Response: out_valid drops without waiting for a clock edge; after release, in_ready=1.
  - Then issue PC=0xFFFFFFFC, imm=8 → PC_wb=0, PC_jump=0x4.

Source files
------------

// File: rtl/fu_jump_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fu_jump_pipe
// Brief    : Branch/jump unit with LATENCY-deep stall/flush pipeline; computes
//            branch condition, jump target and PC+4 link value.
//            Optional macro FU_JUMP_JALR_ALIGN_EN clears target bit 0 on JALR.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module fu_jump_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             JALR,
    input  logic [2:0]       cmp_ctrl,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  PC,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  PC_jump,
    output logic [XLEN-1:0]  PC_wb,
    output logic             cmp_res,
    output logic [TAG_W-1:0] tag_out
);

    localparam int       LAST      = LATENCY - 1;
    localparam bit [2:0] c_CMP_EQ  = 3'b001;
    localparam bit [2:0] c_CMP_NE  = 3'b010;
    localparam bit [2:0] c_CMP_LT  = 3'b011;
    localparam bit [2:0] c_CMP_GE  = 3'b100;
    localparam bit [2:0] c_CMP_LTU = 3'b101;
    localparam bit [2:0] c_CMP_GEU = 3'b110;

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    logic [LATENCY-1:0] jalr_q;
    logic [2:0]         cmp_ctrl_q [LATENCY];
    logic [XLEN-1:0]    rs1_q      [LATENCY];
    logic [XLEN-1:0]    rs2_q      [LATENCY];
    logic [XLEN-1:0]    imm_q      [LATENCY];
    logic [XLEN-1:0]    pc_q       [LATENCY];
    logic [TAG_W-1:0]   tag_q      [LATENCY];

    logic               w_stall;
    logic               w_issue;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_sum;
    logic               w_cmp;

    // The whole pipe holds while the tail result is not taken; bubbles never collapse.
    assign w_stall  = valid_q[LAST] & ~out_ready;
    assign in_ready = ~w_stall & ~flush;
    assign w_issue  = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (!w_stall) begin
            valid_d[0] = w_issue;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            jalr_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                cmp_ctrl_q[i] <= '0;
                rs1_q[i]      <= '0;
                rs2_q[i]      <= '0;
                imm_q[i]      <= '0;
                pc_q[i]       <= '0;
                tag_q[i]      <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (!w_stall) begin
                if (w_issue) begin
                    jalr_q[0]     <= JALR;
                    cmp_ctrl_q[0] <= cmp_ctrl;
                    rs1_q[0]      <= rs1_data;
                    rs2_q[0]      <= rs2_data;
                    imm_q[0]      <= imm;
                    pc_q[0]       <= PC;
                    tag_q[0]      <= tag_in;
                end
                for (int i = 1; i < LATENCY; i++) begin
                    jalr_q[i]     <= jalr_q[i-1];
                    cmp_ctrl_q[i] <= cmp_ctrl_q[i-1];
                    rs1_q[i]      <= rs1_q[i-1];
                    rs2_q[i]      <= rs2_q[i-1];
                    imm_q[i]      <= imm_q[i-1];
                    pc_q[i]       <= pc_q[i-1];
                    tag_q[i]      <= tag_q[i-1];
                end
            end
        end
    end

    always_comb begin
        w_cmp = 1'b0;
        case (cmp_ctrl_q[LAST])
            c_CMP_EQ:  w_cmp = (rs1_q[LAST] == rs2_q[LAST]);
            c_CMP_NE:  w_cmp = (rs1_q[LAST] != rs2_q[LAST]);
            c_CMP_LT:  w_cmp = ($signed(rs1_q[LAST]) <  $signed(rs2_q[LAST]));
            c_CMP_GE:  w_cmp = ($signed(rs1_q[LAST]) >= $signed(rs2_q[LAST]));
            c_CMP_LTU: w_cmp = (rs1_q[LAST] <  rs2_q[LAST]);
            c_CMP_GEU: w_cmp = (rs1_q[LAST] >= rs2_q[LAST]);
            default:   w_cmp = 1'b0;
        endcase
    end

    assign w_base = jalr_q[LAST] ? rs1_q[LAST] : pc_q[LAST];
    assign w_sum  = w_base + imm_q[LAST];

`ifdef FU_JUMP_JALR_ALIGN_EN
    assign PC_jump = jalr_q[LAST] ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
`else
    assign PC_jump = w_sum;
`endif

    assign out_valid = valid_q[LAST];
    assign PC_wb     = pc_q[LAST] + XLEN'(4);
    assign cmp_res   = w_cmp;
    assign tag_out   = tag_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_fu_jump_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_jump_pipe
// Brief    : Directed self-checking bench for fu_jump_pipe (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_jump_pipe;

    localparam int XLEN    = 32;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             JALR;
    logic [2:0]       cmp_ctrl;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  PC;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  PC_jump;
    logic [XLEN-1:0]  PC_wb;
    logic             cmp_res;
    logic [TAG_W-1:0] tag_out;

    int checks = 0;
    int errors = 0;

    fu_jump_pipe #(.XLEN(XLEN), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .JALR(JALR), .cmp_ctrl(cmp_ctrl),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .PC(PC),
        .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC_jump(PC_jump), .PC_wb(PC_wb), .cmp_res(cmp_res), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic j, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc,
                         input logic [3:0] tg);
        in_valid = 1'b1; JALR = j; cmp_ctrl = op;
        rs1_data = a; rs2_data = b; imm = im; PC = pc; tag_in = tg;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'b000, 0, 0, 0, 0, 0);
        idle();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (tag_out !== 4'h0) begin errors++; $display("FAIL reset_tag_out: got %h want 0", tag_out); end
        checks++; if (PC_jump !== 32'h0) begin errors++; $display("FAIL reset_pc_jump: got %h want 0", PC_jump); end
        checks++; if (PC_wb !== 32'h4) begin errors++; $display("FAIL reset_pc_wb: got %h want 4", PC_wb); end
        checks++; if (cmp_res !== 1'b0) begin errors++; $display("FAIL reset_cmp_res: got %b want 0", cmp_res); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_basic_latency;
        drive(1'b0, 3'b001, 32'd5, 32'd5, 32'h20, 32'h100, 4'd3);
        tick();
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (PC_jump !== 32'h120) begin errors++; $display("FAIL basic_pc_jump: got %h want 120", PC_jump); end
        checks++; if (PC_wb !== 32'h104) begin errors++; $display("FAIL basic_pc_wb: got %h want 104", PC_wb); end
        checks++; if (cmp_res !== 1'b1) begin errors++; $display("FAIL basic_cmp: got %b want 1", cmp_res); end
        checks++; if (tag_out !== 4'd3) begin errors++; $display("FAIL basic_tag: got %0d want 3", tag_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_signed_unsigned;
        drive(1'b0, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h200, 4'd7);
        tick();
        drive(1'b0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h204, 4'd8);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || tag_out !== 4'd7 || cmp_res !== 1'b1) begin
            errors++; $display("FAIL lt_signed: valid %b tag %0d cmp %b want 1/7/1", out_valid, tag_out, cmp_res); end
        tick();
        checks++; if (out_valid !== 1'b1 || tag_out !== 4'd8 || cmp_res !== 1'b0) begin
            errors++; $display("FAIL ltu_unsigned: valid %b tag %0d cmp %b want 1/8/0", out_valid, tag_out, cmp_res); end
        tick();
    endtask

    // All eight encodings for (-1 vs 1) then (-8 vs -8), issued back to back.
    task automatic test_compare_ops;
        logic [15:0] exp_bits;
        logic [31:0] a;
        logic [31:0] b;
        exp_bits = {8'b0101_0010, 8'b0100_1100};
        for (int j = 0; j <= 16; j++) begin
            if (j < 16) begin
                a = (j < 8) ? 32'hFFFF_FFFF : 32'hFFFF_FFF8;
                b = (j < 8) ? 32'h0000_0001 : 32'hFFFF_FFF8;
                drive(1'b0, 3'(j % 8), a, b, 32'd0, 32'h300, 4'(j));
            end else begin
                idle();
            end
            tick();
            if (j >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || tag_out !== 4'(j-1) || cmp_res !== exp_bits[j-1]) begin
                    errors++;
                    $display("FAIL cmp_op_%0d: valid %b tag %0d cmp %b want 1/%0d/%b",
                             j-1, out_valid, tag_out, cmp_res, j-1, exp_bits[j-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_jalr;
        logic [31:0] exp_jalr;
`ifdef FU_JUMP_JALR_ALIGN_EN
        exp_jalr = 32'h2004;
`else
        exp_jalr = 32'h2005;
`endif
        drive(1'b1, 3'b000, 32'h2001, 32'd0, 32'h4, 32'h500, 4'd9);
        tick();
        drive(1'b0, 3'b000, 32'h2001, 32'd0, 32'h4, 32'h1001, 4'd10);
        tick();
        idle();
        checks++; if (PC_jump !== exp_jalr || PC_wb !== 32'h504 || cmp_res !== 1'b0) begin
            errors++; $display("FAIL jalr_target: jump %h wb %h cmp %b want %h/504/0", PC_jump, PC_wb, cmp_res, exp_jalr); end
        tick();
        checks++; if (out_valid !== 1'b1 || PC_jump !== 32'h1005) begin
            errors++; $display("FAIL jal_odd_target: valid %b jump %h want 1/1005", out_valid, PC_jump); end
        tick();
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 3'b001, 32'd1, 32'd1, 32'h10, 32'h1000, 4'd1);
        tick();
        drive(1'b0, 3'b001, 32'd1, 32'd2, 32'h10, 32'h2000, 4'd2);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 3'b001, 32'd3, 32'd3, 32'h10, 32'h3000, 4'd3);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || tag_out !== 4'd1 || PC_wb !== 32'h1004 ||
                PC_jump !== 32'h1010 || cmp_res !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid %b tag %0d wb %h jump %h cmp %b in_ready %b want 1/1/1004/1010/1/0",
                         i, out_valid, tag_out, PC_wb, PC_jump, cmp_res, in_ready);
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || tag_out !== 4'd2 || cmp_res !== 1'b0) begin
            errors++; $display("FAIL order_tag2: valid %b tag %0d cmp %b want 1/2/0", out_valid, tag_out, cmp_res); end
        tick();
        checks++; if (out_valid !== 1'b1 || tag_out !== 4'd3 || PC_wb !== 32'h3004) begin
            errors++; $display("FAIL order_tag3: valid %b tag %0d wb %h want 1/3/3004", out_valid, tag_out, PC_wb); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        drive(1'b0, 3'b001, 32'd0, 32'd0, 32'd0, 32'h4000, 4'd4);
        tick();
        drive(1'b0, 3'b001, 32'd0, 32'd0, 32'd0, 32'h5000, 4'd5);
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b0, 3'b001, 32'd0, 32'd0, 32'd0, 32'h6000, 4'd6);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_valid_%0d: out_valid %b tag %0d want 0", i, out_valid, tag_out);
            end
            tick();
        end
    endtask

    task automatic test_async_reset_wrap;
        drive(1'b0, 3'b010, 32'd1, 32'd2, 32'h40, 32'h7000, 4'd12);
        tick();
        idle();
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || tag_out !== 4'd0 || PC_wb !== 32'h4 || PC_jump !== 32'h0) begin
            errors++; $display("FAIL async_reset: valid %b tag %0d wb %h jump %h want 0/0/4/0", out_valid, tag_out, PC_wb, PC_jump); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: out_valid %b want 0", out_valid); end
        drive(1'b0, 3'b000, 32'd0, 32'd0, 32'h8, 32'hFFFF_FFFC, 4'd11);
        tick();
        idle();
        tick();
        checks++; if (out_valid !== 1'b1 || PC_wb !== 32'h0 || PC_jump !== 32'h4 || tag_out !== 4'd11) begin
            errors++; $display("FAIL wrap: valid %b wb %h jump %h tag %0d want 1/0/4/11", out_valid, PC_wb, PC_jump, tag_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_signed_unsigned();
        test_compare_ops();
        test_jalr();
        test_back_to_back();
        test_flush();
        test_async_reset_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
